// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ctrl_pkg
// Summary  : Shared FSM states, RV32 opcode/funct fields, ALU encodings and the
//            instruction decoder used by the multicycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_TRAP      = 3'd4
    } state_t;

    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;

    localparam logic [2:0] C_F3_ADD_SUB = 3'b000;
    localparam logic [2:0] C_F3_AND     = 3'b111;
    localparam logic [2:0] C_F3_OR      = 3'b110;
    localparam logic [2:0] C_F3_BEQ     = 3'b000;
    localparam logic [2:0] C_F3_BNE     = 3'b001;

    localparam logic [6:0] C_F7_BASE    = 7'b0000000;
    localparam logic [6:0] C_F7_ALT     = 7'b0100000;

    localparam logic [2:0] C_ALU_ADD    = 3'b000;
    localparam logic [2:0] C_ALU_SUB    = 3'b001;
    localparam logic [2:0] C_ALU_AND    = 3'b010;
    localparam logic [2:0] C_ALU_OR     = 3'b011;

    typedef struct packed {
        logic       legal;
        logic       alusrc;
        logic [2:0] aluctrl;
        logic       writes;
        logic       is_jal;
        logic       is_beq;
        logic       is_bne;
    } dec_t;

    // Anything not explicitly matched stays all-zero, i.e. illegal with idle controls.
    function automatic dec_t decode_instr(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic [6:0] funct7
    );
        dec_t d;
        d = '0;
        case (opcode)
            C_OPC_OP_IMM: begin
                if (funct3 == C_F3_ADD_SUB) begin
                    d.legal   = 1'b1;
                    d.alusrc  = 1'b1;
                    d.aluctrl = C_ALU_ADD;
                    d.writes  = 1'b1;
                end
            end
            C_OPC_OP: begin
                case (funct3)
                    C_F3_ADD_SUB: begin
                        if (funct7 == C_F7_BASE) begin
                            d.legal   = 1'b1;
                            d.aluctrl = C_ALU_ADD;
                            d.writes  = 1'b1;
                        end else if (funct7 == C_F7_ALT) begin
                            d.legal   = 1'b1;
                            d.aluctrl = C_ALU_SUB;
                            d.writes  = 1'b1;
                        end
                    end
                    C_F3_AND: begin
                        if (funct7 == C_F7_BASE) begin
                            d.legal   = 1'b1;
                            d.aluctrl = C_ALU_AND;
                            d.writes  = 1'b1;
                        end
                    end
                    C_F3_OR: begin
                        if (funct7 == C_F7_BASE) begin
                            d.legal   = 1'b1;
                            d.aluctrl = C_ALU_OR;
                            d.writes  = 1'b1;
                        end
                    end
                    default: d = '0;
                endcase
            end
            C_OPC_BRANCH: begin
                if (funct3 == C_F3_BEQ) begin
                    d.legal   = 1'b1;
                    d.aluctrl = C_ALU_SUB;
                    d.is_beq  = 1'b1;
                end else if (funct3 == C_F3_BNE) begin
                    d.legal   = 1'b1;
                    d.aluctrl = C_ALU_SUB;
                    d.is_bne  = 1'b1;
                end
            end
            C_OPC_JAL: begin
                d.legal   = 1'b1;
                d.aluctrl = C_ALU_ADD;
                d.writes  = 1'b1;
                d.is_jal  = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Summary  : Combinational immediate extraction (I/B/J formats) from the IR.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] ir,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [6:0] w_opcode;
    logic       w_sign;

    assign w_opcode = ir[6:0];
    assign w_sign   = ir[31];

    // R-type and unknown opcodes yield zero so a reset IR presents ImmOp=0.
    always_comb begin
        imm = '0;
        case (w_opcode)
            C_OPC_OP_IMM: imm = {{(DATA_WIDTH-12){w_sign}}, ir[31:20]};
            C_OPC_BRANCH: imm = {{(DATA_WIDTH-13){w_sign}}, ir[31], ir[7],
                                 ir[30:25], ir[11:8], 1'b0};
            C_OPC_JAL:    imm = {{(DATA_WIDTH-21){w_sign}}, ir[31], ir[19:12],
                                 ir[20], ir[30:21], 1'b0};
            default:      imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Summary  : Four-phase (fetch/decode/execute/writeback) RV32 subset controller
//            with PC sequencing and a sticky trap on unsupported instructions.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC      = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     EQ,
    output logic [DATA_WIDTH-1:0]    PC,
    output logic [DATA_WIDTH-1:0]    next_PC,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    output logic                     ALUsrc,
    output logic [2:0]               ALUctrl,
    output logic                     RegWrite,
    output logic                     jumpSaveNext,
    output logic                     illegal
);

    localparam logic [DATA_WIDTH-1:0] C_PC_STEP = DATA_WIDTH'(4);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   r_ir;
    dec_t                    r_dec;
    logic                    r_taken;
    logic                    r_illegal;
    logic                    r_regwrite;
    logic                    r_jump_save;
    logic [DATA_WIDTH-1:0]   w_imm;
    logic [ADDRESS_WIDTH-1:0] w_rd;

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .ir  (r_ir),
        .imm (w_imm)
    );

    assign w_rd = r_ir[7 +: ADDRESS_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_dec       <= '0;
            r_taken     <= 1'b0;
            r_illegal   <= 1'b0;
            r_regwrite  <= 1'b0;
            r_jump_save <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // Decode is captured with the IR so ALU controls are stable from DECODE on.
                    if (instr_valid && instr_ready) begin
                        r_ir    <= instr;
                        r_dec   <= decode_instr(instr[6:0], instr[14:12], instr[31:25]);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_dec.legal) begin
                        r_state <= S_EXECUTE;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= S_TRAP;
                    end
                end
                S_EXECUTE: begin
                    r_taken     <= (r_dec.is_beq & EQ) | (r_dec.is_bne & ~EQ);
                    r_regwrite  <= r_dec.writes && (w_rd != '0);
                    r_jump_save <= r_dec.is_jal;
                    r_state     <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (r_taken || r_dec.is_jal) begin
                        r_pc <= r_pc + w_imm;
                    end else begin
                        r_pc <= r_pc + C_PC_STEP;
                    end
                    r_taken     <= 1'b0;
                    r_regwrite  <= 1'b0;
                    r_jump_save <= 1'b0;
                    r_state     <= S_FETCH;
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_TRAP;
                end
            endcase
        end
    end

    assign instr_ready  = (r_state == S_FETCH);
    assign PC           = r_pc;
    assign next_PC      = r_pc + C_PC_STEP;
    assign rs1          = r_ir[15 +: ADDRESS_WIDTH];
    assign rs2          = r_ir[20 +: ADDRESS_WIDTH];
    assign rd           = w_rd;
    assign ImmOp        = w_imm;
    assign ALUsrc       = r_dec.alusrc;
    assign ALUctrl      = r_dec.aluctrl;
    assign RegWrite     = r_regwrite;
    assign jumpSaveNext = r_jump_save;
    assign illegal      = r_illegal;

endmodule
`default_nettype wire
